rv_dmem_responder: RTL
======================

# rv_dmem_responder

Data-memory responder for the rv_cpu load/store port: it accepts the core's `t_core2mem_req` in Q103H and performs byte-enabled writes and sign- or zero-extended reads. It inserts a configurable number of wait states and reports them to the core through a ready handshake. It is the target side of the `core2dmem_req`/`dmem_rd_data` interface and sits beside the instruction memory in the unified memory wrapper. It lets the pipeline's stall logic be exercised against a non-ideal memory.

## Interface
- `DMEM_SIZE_BYTES`, 1024 — storage size; power of two, at least 4.
- `WAIT_CYCLES`, 0 — wait states inserted per accepted access; range 0..15.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, synchronous, active-high.
- `core2dmem_req` in `t_core2mem_req` — fields `address[31:0]`, `wr_data[31:0]`, `wr_en`, `rd_en`, `byte_en[3:0]`.
- `dmem_is_signed_Q103H` in 1 — sign-extend byte/half reads.
- `dmem_ready_Q103H` out 1 — high means a request is accepted this cycle; low means the core must stall and hold its request stable.
- `dmem_rd_data_Q104H` out 32 — extended read data.
- `dmem_rd_valid_Q104H` out 1 — single-cycle pulse when `dmem_rd_data_Q104H` is valid.
- `dmem_misalign_err_Q104H` out 1 — misaligned-access pulse (see Configuration).

## Operation
- **Access size.** `byte_en` is an unshifted size mask: 0001 = byte, 0011 = half, 1111 = word.
  - Byte lane offset is `address[1:0]`.
  - `wr_data` is low-aligned; the block shifts it onto the addressed lanes.
  - Any other `byte_en` value is treated as word.
- **Address range.** Index = `address[$clog2(DMEM_SIZE_BYTES)-1:0]`; out-of-range addresses wrap modulo the size.
- **Accept.** A request is accepted when `(rd_en|wr_en) && dmem_ready_Q103H`. If both enables are set, the write wins and no `rd_valid` is produced.
- **FSM states.** IDLE and WAIT.
  - IDLE: `ready=1`.
    - Accept with `WAIT_CYCLES==0`: access is performed at the accept edge; the FSM stays in IDLE.
    - Accept with `WAIT_CYCLES>0`: the request is latched, `cnt` is set to `WAIT_CYCLES-1`, and the FSM moves to WAIT.
  - WAIT: `ready=0`; `cnt` decrements each cycle.
    - When `cnt==0`, the latched access is performed at that edge and the FSM returns to IDLE.
- **Access.**
  - Write: commits only the enabled lanes.
  - Read: selects the lanes, then sign-extends (if `is_signed`) or zero-extends to 32 bits into the `rd_data` register, and sets `rd_valid` for one cycle.
- **Output hold.** `rd_data` keeps its last value until the next read.
- **Back-to-back requests.** In IDLE, a new request in the same cycle that `rd_valid` is high is accepted with no bubble.
- **Read-after-write.** A read in the cycle after a write to the same address returns the new data.
- **Storage.** Contents are not cleared by reset; the testbench preloads them by hierarchical reference.

## Timing
- **Reset values:** `dmem_ready_Q103H=0` while `rst` is high, and 1 in the first cycle after `rst` falls. `dmem_rd_data_Q104H=0`, `dmem_rd_valid_Q104H=0`, `dmem_misalign_err_Q104H=0`; FSM is in IDLE.
- **Read latency:** `WAIT_CYCLES+1` cycles from the accept edge to the `rd_valid` cycle. With `WAIT_CYCLES=0` this is Q103H → Q104H.
- **Ready low time:** exactly `WAIT_CYCLES` cycles after each accept; the next accept is possible in the following cycle.
- **Reset mid-operation:** `rst` in WAIT returns the FSM to IDLE and discards the latched request. The write is not committed and no `rd_valid` is produced.

## Configuration
- Macro: `RV_DMEM_MISALIGN_CHK_EN`.
- **Defined:**
  - A half access with `address[0]=1`, or a word access with `address[1:0]!=0`, is still accepted normally and takes the normal wait states.
  - A misaligned write is dropped.
  - A misaligned read returns `rd_data=0` with `rd_valid`.
  - `misalign_err` pulses in the same cycle `rd_valid` would pulse (one cycle after the access edge), for both reads and writes.
- **Undefined:**
  - `misalign_err` is tied to 0.
  - Misaligned addresses are force-aligned: `address[0]` is cleared for half accesses and `address[1:0]` for word accesses.

## Structure
- Additions to `rv_pkg`:
  - `t_dmem_state` enum (`DMEM_IDLE`, `DMEM_WAIT`).
  - Size-mask localparams `BE_BYTE`/`BE_HALF`/`BE_WORD`.
  - `t_core2mem_req` is reused unchanged.
- Sub-module `rv_dmem_array`: four byte-wide banks, each `DMEM_SIZE_BYTES/4` deep, with per-lane write enable and synchronous read. It exposes `mem` for hierarchical preload.
- Top level contains the FSM, wait counter, request latch, lane shift and extension logic.

## Test plan
- **Word write/read, `WAIT_CYCLES=0`:** write `0xDEADBEEF` to 0x10, then read 0x10 in the next cycle. Expect `rd_valid` one cycle later with `0xDEADBEEF`, and `ready` held at 1 throughout.
- **Byte/half extension:** with word `0x80FF7F01` at 0x20:
  - signed byte read at 0x23 returns `0xFFFFFF80`;
  - unsigned byte read at 0x21 returns `0x0000007F`;
  - signed half read at 0x22 returns `0xFFFF80FF`.
- **Byte write merge:** byte write `0xAA` to 0x31 over `0x11223344` at 0x30; a word read returns `0x1122AA44`.
- **Wait states, `WAIT_CYCLES=3`:** a read accepted at cycle N gives `ready` low for cycles N+1..N+3 and `rd_valid` at N+4. A second request held during the wait is accepted at N+4.
- **Reset in WAIT, `WAIT_CYCLES=3`:** a write of `0x55` to 0x40 is followed by `rst` at N+2. Memory at 0x40 is unchanged, `ready` is 0 during reset and 1 after, and no `rd_valid` appears.
- **Misaligned word read at 0x41:** with the macro defined, `misalign_err=1`, `rd_valid=1`, `rd_data=0`. Without the macro, the read returns the word at 0x40 and `misalign_err=0`.

Source files
------------

// File: rtl/rv_dmem_responder_pkg.sv
// rtl/rv_dmem_responder_pkg.sv - shared types for the rv_cpu data-memory responder
package rv_dmem_responder_pkg;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;

  typedef enum logic [0:0] {
    DMEM_IDLE = 1'b0,
    DMEM_WAIT = 1'b1
  } t_dmem_state;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } t_dmem_size;

  // Unrecognised size masks fall back to a full word.
  function automatic t_dmem_size dmem_size(input logic [3:0] be);
    if (be == BE_BYTE) return SZ_BYTE;
    if (be == BE_HALF) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/rv_dmem_responder_if.sv
// rtl/rv_dmem_responder_if.sv - core-to-data-memory request/response bundle
interface rv_dmem_responder_if;
  import rv_dmem_responder_pkg::*;

  t_core2mem_req core2dmem_req;
  logic          dmem_is_signed_Q103H;
  logic          dmem_ready_Q103H;
  logic [31:0]   dmem_rd_data_Q104H;
  logic          dmem_rd_valid_Q104H;
  logic          dmem_misalign_err_Q104H;

  modport master (
    output core2dmem_req, dmem_is_signed_Q103H,
    input  dmem_ready_Q103H, dmem_rd_data_Q104H, dmem_rd_valid_Q104H, dmem_misalign_err_Q104H
  );

  modport slave (
    input  core2dmem_req, dmem_is_signed_Q103H,
    output dmem_ready_Q103H, dmem_rd_data_Q104H, dmem_rd_valid_Q104H, dmem_misalign_err_Q104H
  );
endinterface

// File: rtl/rv_dmem_responder_array.sv
// rtl/rv_dmem_responder_array.sv - four byte-wide banks with lane write enables and registered read
// Storage is left uninitialised; mem is preloaded hierarchically.
module rv_dmem_array #(
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [7:0] mem [4][DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) mem[l][idx] <= wr_data[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'h0;
    end else if (re) begin
      for (int l = 0; l < 4; l++) rd_data[8*l +: 8] <= mem[l][idx];
    end
  end

endmodule

// File: rtl/rv_dmem_responder.sv
// rtl/rv_dmem_responder.sv - data-memory responder with wait states and sign/zero-extended reads
// Optional misalignment checking: RV_DMEM_MISALIGN_CHK_EN.
module rv_dmem_responder
  import rv_dmem_responder_pkg::*;
#(
  parameter int DMEM_SIZE_BYTES = 1024,
  parameter int WAIT_CYCLES     = 0
) (
  input  logic             clk,
  input  logic             rst,
  rv_dmem_responder_if.slave bus
);

  localparam int DEPTH = DMEM_SIZE_BYTES / 4;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE = 1'(DMEM_IDLE);
  localparam logic [0:0] ST_WAIT = 1'(DMEM_WAIT);

  logic [0:0]    state;
  logic [3:0]    cnt;
  t_core2mem_req lat_req;
  logic          lat_signed;

  logic          ready;
  logic          accept;
  logic          acc_go;
  t_core2mem_req acc_req;
  logic          acc_signed;

  t_dmem_size    sz;
  logic [1:0]    off;
  logic [1:0]    eff_off;
  logic          misalign;
  logic          drop;
  logic          is_wr;
  logic          is_rd;
  logic [3:0]    lane_mask;
  logic [31:0]   word_addr;

  logic [3:0]    arr_we;
  logic          arr_re;
  logic [31:0]   arr_wdata;
  logic [31:0]   arr_rdata;

  logic [1:0]    rd_off;
  t_dmem_size    rd_sz;
  logic          rd_signed;
  logic          rd_zero;
  logic          rd_valid;
  logic          misalign_err;
  logic [31:0]   shifted;
  logic [31:0]   ext_data;
  logic          unused_bits;

  assign ready  = !rst && (state == ST_IDLE);
  assign accept = (bus.core2dmem_req.rd_en || bus.core2dmem_req.wr_en) && ready;

  // Zero wait states act on the live request; otherwise the latched copy is used.
  always_comb begin
    acc_go     = 1'b0;
    acc_req    = bus.core2dmem_req;
    acc_signed = bus.dmem_is_signed_Q103H;
    if (WAIT_CYCLES == 0) begin
      acc_go = accept;
    end else begin
      acc_go     = !rst && (state == ST_WAIT) && (cnt == 4'd0);
      acc_req    = lat_req;
      acc_signed = lat_signed;
    end
  end

  assign sz       = dmem_size(acc_req.byte_en);
  assign off      = acc_req.address[1:0];
  assign misalign = ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
  assign is_wr    = acc_req.wr_en;
  assign is_rd    = acc_req.rd_en && !acc_req.wr_en;

  always_comb begin
    eff_off = off;
    drop    = 1'b0;
`ifdef RV_DMEM_MISALIGN_CHK_EN
    drop = misalign;
`else
    if (sz == SZ_HALF) eff_off[0] = 1'b0;
    else if (sz == SZ_WORD) eff_off = 2'b00;
`endif
  end

  always_comb begin
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << eff_off;
      SZ_HALF: lane_mask = 4'b0011 << eff_off;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign word_addr = acc_req.address >> 2;
  assign arr_we    = (acc_go && is_wr && !drop) ? lane_mask : 4'b0000;
  assign arr_re    = acc_go && is_rd && !drop;
  assign arr_wdata = acc_req.wr_data << {eff_off, 3'b000};

  rv_dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .re      (arr_re),
    .idx     (word_addr[IW-1:0]),
    .wr_data (arr_wdata),
    .rd_data (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (WAIT_CYCLES > 0)) begin
            cnt   <= 4'(WAIT_CYCLES - 1);
            state <= ST_WAIT;
          end
        end
        default: begin
          if (cnt == 4'd0) state <= ST_IDLE;
          else cnt <= cnt - 4'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_req    <= bus.core2dmem_req;
      lat_signed <= bus.dmem_is_signed_Q103H;
    end
  end

  // Lane selection metadata follows the raw word so extension happens after the bank read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_off    <= 2'b00;
      rd_sz     <= SZ_WORD;
      rd_signed <= 1'b0;
      rd_zero   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= acc_go && is_rd;
      if (acc_go && is_rd) begin
        rd_off    <= eff_off;
        rd_sz     <= sz;
        rd_signed <= acc_signed;
        rd_zero   <= drop;
      end
    end
  end

`ifdef RV_DMEM_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else misalign_err <= acc_go && misalign;
  end
  assign unused_bits = ^{word_addr[31:IW]};
`else
  assign misalign_err = 1'b0;
  assign unused_bits  = ^{word_addr[31:IW], misalign};
`endif

  assign shifted = arr_rdata >> {rd_off, 3'b000};

  always_comb begin
    case (rd_sz)
      SZ_BYTE: ext_data = {{24{rd_signed & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ext_data = {{16{rd_signed & shifted[15]}}, shifted[15:0]};
      default: ext_data = shifted;
    endcase
  end

  assign bus.dmem_ready_Q103H        = ready;
  assign bus.dmem_rd_data_Q104H      = rd_zero ? 32'h0 : ext_data;
  assign bus.dmem_rd_valid_Q104H     = rd_valid;
  assign bus.dmem_misalign_err_Q104H = misalign_err;

endmodule
